// File: rtl/bcollector.sv
// Serial-to-parallel collector: rebuilds WIDTH-bit words LSB- or MSB-first; word valid the cycle after its last bit,
// held until res_ready; i_ready drops while a word is held. Optional parity bit under BCOLLECTOR_PARITY_EN.
module bcollector #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             ssl,
  input  logic             flush,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] cnt,
  output logic             par_err
);

  typedef enum logic [1:0] {COLLECT, PARITY, HOLD} state_t;

`ifdef BCOLLECTOR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_shift;
  logic             dir, dir_eff;
  logic             accept, take;

  // Direction is taken live on the first bit, then from the latch.
  assign dir_eff  = (cnt == '0) ? ssl : dir;
  assign sr_shift = dir_eff ? {i, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], i};

  always_ff @(posedge clock) begin
    if (reset) state <= COLLECT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    take      = 1'b0;
    case (state)
      COLLECT: begin
        i_ready = !reset;
        if (!flush && i_valid) begin
          accept = 1'b1;
          if (cnt == LAST) state_nxt = PAR_EN ? PARITY : HOLD;
        end
      end
      PARITY: begin
        i_ready = !reset;
        if (flush)        state_nxt = COLLECT;
        else if (i_valid) state_nxt = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          take      = 1'b1;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr  <= '0;
      res <= '0;
      cnt <= '0;
      dir <= 1'b0;
    end else if (flush && state != HOLD) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= sr_shift;
      cnt <= cnt + CNT_W'(1);
      if (cnt == '0) dir <= ssl;
      if (cnt == LAST) res <= sr_shift;
    end else if (take) begin
      sr  <= '0;
      cnt <= '0;
    end
  end

`ifdef BCOLLECTOR_PARITY_EN
  logic par_acc;
  assign par_acc = (state == PARITY) && !flush && i_valid;

  always_ff @(posedge clock) begin
    if (reset)        par_err <= 1'b0;
    else if (par_acc) par_err <= (^sr) ^ i;
    else if (take)    par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcollector.sv
// Directed bench for bcollector (WIDTH=4); outputs sampled 1 time unit after each rising edge.
module tb_bcollector;
  logic       clock = 1'b0;
  logic       reset, i, i_valid, ssl, flush, res_ready;
  logic       i_ready, res_valid, par_err;
  logic [3:0] res;
  logic [2:0] cnt;
  int         errors = 0;
  int         checks = 0;

  bcollector dut (
    .clock(clock), .reset(reset), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .ssl(ssl), .flush(flush), .res(res), .res_valid(res_valid),
    .res_ready(res_ready), .cnt(cnt), .par_err(par_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic b, input logic s);
    i = b; ssl = s; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  // seq[3] goes first; in the parity build an even parity bit follows.
  task automatic word(input logic [3:0] seq, input logic s);
    for (int k = 3; k >= 0; k--) send(seq[k], s);
`ifdef BCOLLECTOR_PARITY_EN
    send(^seq, s);
`endif
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; i = 1'b0; i_valid = 1'b0; ssl = 1'b0; flush = 1'b0; res_ready = 1'b0;
    tick(); tick();
    check("rst_cnt", cnt, 0);
    check("rst_res", res, 0);
    check("rst_vld", res_valid, 0);
    check("rst_rdy", i_ready, 0);
    check("rst_par", par_err, 0);
    reset = 1'b0;
    #1;
    check("post_rst_rdy", i_ready, 1);

    // Right shift 0,1,1,1 -> 1110
    word(4'b0111, 1'b1);
    check("right_res", res, 4'b1110);
    check("right_vld", res_valid, 1);
    check("right_rdy", i_ready, 0);
    check("right_cnt", cnt, 4);
    handshake();

    // Left shift 1,1,1,0 -> 1110
    word(4'b1110, 1'b0);
    check("left_res", res, 4'b1110);
    handshake();

    // Direction latched on bit 0 (left), ssl toggled afterwards -> 0011
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
`ifdef BCOLLECTOR_PARITY_EN
    send(1'b0, 1'b1);
`endif
    check("latch_res", res, 4'b0011);
    handshake();

    // Backpressure: right 1,0,1,0 -> 0101, held 3 cycles against i_valid
    word(4'b1010, 1'b1);
    i = 1'b1; i_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_rdy", i_ready, 0);
      check("bp_res", res, 4'b0101);
      check("bp_cnt", cnt, 4);
      check("bp_vld", res_valid, 1);
    end
    i_valid = 1'b0;
    handshake();
    check("hs_vld", res_valid, 0);
    check("hs_cnt", cnt, 0);
    check("hs_rdy", i_ready, 1);
    send(1'b1, 1'b1);
    check("bubble_cnt", cnt, 1);

    // Flush with a simultaneous bit, then 1,0,0,1 right -> 1001
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    flush = 1'b1; i = 1'b1; i_valid = 1'b1;
    tick();
    flush = 1'b0; i_valid = 1'b0;
    check("flush_cnt", cnt, 0);
    check("flush_vld", res_valid, 0);
    word(4'b1001, 1'b1);
    check("flush_res", res, 4'b1001);

    // Flush while holding is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("hold_flush_vld", res_valid, 1);
    check("hold_flush_res", res, 4'b1001);
    handshake();

    // Reset mid-word, then left 1,0,1,1 -> 1011
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_vld", res_valid, 0);
    word(4'b1011, 1'b0);
    check("clean_res", res, 4'b1011);
    check("clean_par", par_err, 0);
    handshake();

`ifdef BCOLLECTOR_PARITY_EN
    for (int k = 3; k >= 0; k--) send(k == 3 ? 1'b0 : 1'b1, 1'b1);
    check("par_state_cnt", cnt, 4);
    check("par_state_vld", res_valid, 0);
    send(1'b1, 1'b1);
    check("par_ok_res", res, 4'b1110);
    check("par_ok_err", par_err, 0);
    handshake();
    for (int k = 3; k >= 0; k--) send(k == 3 ? 1'b0 : 1'b1, 1'b1);
    send(1'b0, 1'b1);
    check("par_bad_err", par_err, 1);
    handshake();
    check("par_clr", par_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcollector.md
Name: bcollector

Overview:
- Serial-to-parallel receiver; the counterpart of the 4-bit barrel shifter's serial output `o`.
- Accepts one bit per accepted beat and rebuilds a WIDTH-bit word in a shift register.
- Word direction is selected per word: right-shift (LSB-first) or left-shift (MSB-first).
- Each completed word is presented on a valid/ready output and held until consumed.

Parameters:
- WIDTH, 4, word width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH+1), width of the bit counter and of the `cnt` port.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i  in  1  serial data bit.
- i_valid  in  1  `i` is valid this cycle.
- i_ready  out  1  block can accept `i` this cycle.
- ssl  in  1  direction: 1 = right shift (LSB-first, new bit enters at MSB); 0 = left shift (MSB-first, new bit enters at LSB).
- flush  in  1  discard the partial word.
- res  out  WIDTH  assembled word.
- res_valid  out  1  `res` holds a complete word.
- res_ready  in  1  consumer takes `res`.
- cnt  out  CNT_W  bits accepted for the current word.
- par_err  out  1  parity mismatch flag (optional feature).

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high and has priority over everything.
- Reset values: state=COLLECT; shift reg=0; res=0; res_valid=0; cnt=0; par_err=0. `i_ready` is forced to 0 while reset=1.
- Accept: a bit is taken on a rising edge with i_valid && i_ready. If i_valid=0, nothing changes.
- Direction latch: `ssl` is sampled on the accept beat where cnt==0 and held for the rest of the word. Changes to `ssl` mid-word are ignored.
- Shift rules:
  - right: sr <= {i, sr[WIDTH-1:1]}
  - left: sr <= {sr[WIDTH-2:0], i}
- COLLECT state:
  - i_ready=1 and res_valid=0.
  - Each accepted bit increments `cnt`.
  - Accepting the bit with cnt==WIDTH-1 moves to HOLD (or PARITY if the feature is enabled).
- HOLD state:
  - res = sr, res_valid=1, i_ready=0; `cnt` reads WIDTH.
  - `res` is stable while res_ready=0.
  - res_valid && res_ready: go to COLLECT, cnt=0, res_valid=0 next cycle.
- Latency:
  - Final bit accepted at edge N → res_valid=1 from edge N (visible in cycle N+1).
  - One bubble cycle after a handshake before the next bit can be accepted.
- flush:
  - In COLLECT/PARITY: clears sr and cnt, returns to COLLECT. It beats a simultaneous accept; that bit is dropped.
  - In HOLD: ignored; the held word is not lost.
- Simultaneous i_valid in HOLD: no accept; the producer must hold its bit.
- Wrap: `cnt` never exceeds WIDTH; there is no overflow path.

Optional Feature:
- Macro: BCOLLECTOR_PARITY_EN.
- Defined:
  - After WIDTH data bits, state PARITY (i_ready=1) accepts one more bit `p`.
  - Then go to HOLD with par_err = (^sr) ^ p, i.e. even parity with the parity bit included.
  - par_err is valid while res_valid=1 and clears on the handshake.
  - `cnt` reads WIDTH during PARITY.
  - flush in PARITY discards the whole word.
- Undefined: no PARITY state; par_err is tied to 0.

Test Plan:
- Right shift: WIDTH=4, ssl=1, bits 0,1,1,1 on consecutive beats → after 4th accept res=4'b1110, res_valid=1, i_ready=0.
- Left shift: ssl=0, bits 1,1,1,0 → res=4'b1110. Then toggle ssl mid-next-word with bits 0,0,1,1 → res=4'b0011 (direction latched at bit 0).
- Backpressure: word complete, res_ready=0 for 3 cycles with i_valid=1 → i_ready=0, res unchanged, cnt=4. res_ready=1 → res_valid=0 next cycle, cnt=0, next bit accepted one cycle later.
- Flush: ssl=1, bits 1,1 then flush=1 with i_valid=1, then bits 1,0,0,1 → res=4'b1001, no residue from the dropped bits.
- Reset mid-word: 2 bits accepted then reset=1 for one cycle → cnt=0, res=0, res_valid=0. The next 4 bits form a clean word.
- Parity (BCOLLECTOR_PARITY_EN): ssl=1, bits 0,1,1,1 + p=1 → res=4'b1110, par_err=0. Same data with p=0 → par_err=1.
